// File: rtl/gc_pkg.sv
// Shared types and default parameters for the flash-channel GC scheduler.
package gc_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        HOST,
        GC
    } sched_state_t;

    localparam int unsigned FIFO_SIZE_BIT_NUM_DEF = 4;
    localparam int unsigned LOW_WM_DEF            = 4;
    localparam int unsigned HIGH_WM_DEF           = 12;
    localparam int unsigned STARVE_MAX_DEF        = 8;

    // Width of a counter that must hold values 0..max inclusive.
    function automatic int unsigned cnt_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/gc_channel_sched_if.sv
// Bundle of host, GC-controller and clean-block FIFO signals seen by the scheduler.
interface gc_channel_sched_if
    import gc_pkg::*;
#(
    parameter int unsigned FIFO_SIZE_BIT_NUM = FIFO_SIZE_BIT_NUM_DEF
) ();

    logic                         ini_full;
    logic [FIFO_SIZE_BIT_NUM-1:0] clean_num;
    logic                         host_req;
    logic                         host_done;
    logic                         host_grant;
    logic                         gc_request;
    logic                         request_done;
    logic                         gc_grant;
    logic                         gc_start;
    logic                         gc_interrupt;
    logic                         urgent;

    // Environment side: host front end, GC controller and FIFO status.
    modport master (
        output ini_full, clean_num, host_req, host_done, gc_request, request_done,
        input  host_grant, gc_grant, gc_start, gc_interrupt, urgent
    );

    // Scheduler side.
    modport slave (
        input  ini_full, clean_num, host_req, host_done, gc_request, request_done,
        output host_grant, gc_grant, gc_start, gc_interrupt, urgent
    );

endinterface

// File: rtl/gc_wm_cmp.sv
// Registered watermark comparison of the clean-block count.
module gc_wm_cmp
    import gc_pkg::*;
#(
    parameter int unsigned FIFO_SIZE_BIT_NUM = FIFO_SIZE_BIT_NUM_DEF,
    parameter int unsigned LOW_WM            = LOW_WM_DEF,
    parameter int unsigned HIGH_WM           = HIGH_WM_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [FIFO_SIZE_BIT_NUM-1:0] clean_num,
    output logic                         urgent,
    output logic                         need_gc
);

    // One spare bit so a watermark equal to 2**FIFO_SIZE_BIT_NUM still compares correctly.
    localparam int unsigned CmpW = FIFO_SIZE_BIT_NUM + 1;
    localparam logic [CmpW-1:0] LowWm  = CmpW'(LOW_WM);
    localparam logic [CmpW-1:0] HighWm = CmpW'(HIGH_WM);

    logic [CmpW-1:0] clean_ext;

    assign clean_ext = {1'b0, clean_num};

    always_ff @(posedge CLK) begin
        if (RST) begin
            urgent  <= 1'b0;
            need_gc <= 1'b0;
        end else begin
            urgent  <= clean_ext < LowWm;
            need_gc <= clean_ext < HighWm;
        end
    end

endmodule

// File: rtl/gc_channel_sched.sv
// Flash-channel arbiter between host writes and garbage collection.
// Optional GC preemption by host traffic is enabled with `define GC_PREEMPT_EN.
module gc_channel_sched
    import gc_pkg::*;
#(
    parameter int unsigned FIFO_SIZE_BIT_NUM = FIFO_SIZE_BIT_NUM_DEF,
    parameter int unsigned LOW_WM            = LOW_WM_DEF,
    parameter int unsigned HIGH_WM           = HIGH_WM_DEF,
    parameter int unsigned STARVE_MAX        = STARVE_MAX_DEF
) (
    input logic               CLK,
    input logic               RST,
    gc_channel_sched_if.slave bus
);

    localparam int unsigned StarveW = cnt_width(STARVE_MAX);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

    sched_state_t       state_q, state_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic               gc_pending_q, gc_pending_d;
    logic               gc_seen_q, gc_seen_d;
    logic               gc_start_q, gc_start_d;
    logic               urgent;
    logic               need_gc;
    logic               preempt_win;

    gc_wm_cmp #(
        .FIFO_SIZE_BIT_NUM (FIFO_SIZE_BIT_NUM),
        .LOW_WM            (LOW_WM),
        .HIGH_WM           (HIGH_WM)
    ) u_wm_cmp (
        .CLK       (CLK),
        .RST       (RST),
        .clean_num (bus.clean_num),
        .urgent    (urgent),
        .need_gc   (need_gc)
    );

`ifdef GC_PREEMPT_EN
    logic gc_interrupt_q, gc_interrupt_d;
    logic preempt_q, preempt_d;

    always_comb begin
        gc_interrupt_d = 1'b0;
        preempt_d      = preempt_q;
        if (state_q == GC) begin
            if (bus.request_done) begin
                preempt_d = gc_interrupt_q;
            end else if (gc_interrupt_q || (!urgent && bus.host_req)) begin
                gc_interrupt_d = 1'b1;
            end
        end else if (state_q == IDLE) begin
            // A preemption credit is spent on the first arbitration after GC.
            preempt_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            gc_interrupt_q <= 1'b0;
            preempt_q      <= 1'b0;
        end else begin
            gc_interrupt_q <= gc_interrupt_d;
            preempt_q      <= preempt_d;
        end
    end

    assign preempt_win      = preempt_q && bus.host_req;
    assign bus.gc_interrupt = gc_interrupt_q;
`else
    assign preempt_win      = 1'b0;
    assign bus.gc_interrupt = 1'b0;
`endif

    // State transitions and IDLE arbitration.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT: begin
                if (bus.ini_full) state_d = IDLE;
            end
            IDLE: begin
                if (urgent) begin
                    if (bus.gc_request) state_d = GC;
                end else if (preempt_win) begin
                    state_d = HOST;
                end else if (bus.host_req && bus.gc_request && gc_pending_q) begin
                    state_d = (starve_q == StarveMax) ? GC : HOST;
                end else if (bus.host_req) begin
                    state_d = HOST;
                end else if (bus.gc_request) begin
                    state_d = GC;
                end
            end
            HOST: begin
                if (bus.host_done) state_d = IDLE;
            end
            GC: begin
                if (bus.request_done) state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    // Starve counter only moves on an IDLE decision.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (state_d == GC) begin
                starve_d = '0;
            end else if (state_d == HOST && gc_pending_q && bus.gc_request &&
                         starve_q != StarveMax) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // gc_pending lifecycle: start a pass, remember a GC grant happened, retire once GC goes quiet.
    always_comb begin
        gc_pending_d = gc_pending_q;
        gc_seen_d    = gc_seen_q;
        gc_start_d   = 1'b0;
        if (!gc_pending_q) begin
            gc_seen_d = 1'b0;
            if ((state_q == IDLE || state_q == HOST) && need_gc) begin
                gc_pending_d = 1'b1;
                gc_start_d   = 1'b1;
            end
        end else if (state_q == GC) begin
            gc_seen_d = 1'b1;
        end else if (gc_seen_q && !bus.gc_request) begin
            gc_pending_d = 1'b0;
            gc_seen_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= INIT;
            starve_q     <= '0;
            gc_pending_q <= 1'b0;
            gc_seen_q    <= 1'b0;
            gc_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            gc_pending_q <= gc_pending_d;
            gc_seen_q    <= gc_seen_d;
            gc_start_q   <= gc_start_d;
        end
    end

    assign bus.host_grant = (state_q == HOST);
    assign bus.gc_grant   = (state_q == GC);
    assign bus.gc_start   = gc_start_q;
    assign bus.urgent     = urgent;

endmodule

// File: tb/tb_gc_channel_sched.sv
// Directed self-checking bench for gc_channel_sched.
module tb_gc_channel_sched;
    import gc_pkg::*;

`ifdef GC_PREEMPT_EN
    localparam int ExpInt = 1;
`else
    localparam int ExpInt = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    gc_channel_sched_if #(.FIFO_SIZE_BIT_NUM(4)) bus ();

    gc_channel_sched #(
        .FIFO_SIZE_BIT_NUM (4),
        .LOW_WM            (4),
        .HIGH_WM           (12),
        .STARVE_MAX        (8)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.ini_full     = 1'b0;
        bus.clean_num    = 4'd13;
        bus.host_req     = 1'b0;
        bus.host_done    = 1'b0;
        bus.gc_request   = 1'b0;
        bus.request_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        int exp_gc;

        // Reset state
        do_reset();
        check("rst_host_grant", int'(bus.host_grant), 0);
        check("rst_gc_grant", int'(bus.gc_grant), 0);
        check("rst_gc_start", int'(bus.gc_start), 0);
        check("rst_urgent", int'(bus.urgent), 0);
        check("rst_gc_interrupt", int'(bus.gc_interrupt), 0);
        check("rst_state", int'(dut.state_q), int'(INIT));

        // Init gating
        bus.host_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("init_no_grant", int'(bus.host_grant), 0);
        end
        bus.ini_full = 1'b1;
        tick();
        check("init_idle_no_grant", int'(bus.host_grant), 0);
        tick();
        check("init_host_grant", int'(bus.host_grant), 1);
        bus.host_req  = 1'b0;
        bus.host_done = 1'b1;
        tick();
        bus.host_done = 1'b0;
        check("host_done_release", int'(bus.host_grant), 0);

        // Threshold trigger: 13 never starts GC, 11 starts exactly once
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.gc_start) pulses++;
        end
        check("no_start_at_13", pulses, 0);
        bus.clean_num = 4'd11;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (bus.gc_start) pulses++;
        end
        check("one_start_at_11", pulses, 1);

        // Urgent priority and host blocking
        bus.clean_num = 4'd3;
        tick();
        check("urgent_set", int'(bus.urgent), 1);
        bus.host_req   = 1'b1;
        bus.gc_request = 1'b1;
        tick();
        check("urgent_gc_grant", int'(bus.gc_grant), 1);
        check("urgent_host_denied", int'(bus.host_grant), 0);
        bus.gc_request   = 1'b0;
        bus.request_done = 1'b1;
        tick();
        bus.request_done = 1'b0;
        check("urgent_gc_release", int'(bus.gc_grant), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("urgent_host_blocked", int'(bus.host_grant), 0);
        end
        bus.clean_num = 4'd4;
        tick();
        check("urgent_clear", int'(bus.urgent), 0);
        check("host_wait_decision", int'(bus.host_grant), 0);
        tick();
        check("host_after_urgent", int'(bus.host_grant), 1);
        bus.host_req  = 1'b0;
        bus.host_done = 1'b1;
        bus.clean_num = 4'd0;
        tick();
        bus.host_done = 1'b0;
        check("urgent_at_zero", int'(bus.urgent), 1);

        // Anti-starvation: 8 host grants then one GC grant, twice
        do_reset();
        bus.ini_full  = 1'b1;
        bus.clean_num = 4'd8;
        tick();
        tick();
        check("starve_gc_start", int'(bus.gc_start), 1);
        tick();
        bus.host_req   = 1'b1;
        bus.gc_request = 1'b1;
        for (int g = 0; g < 18; g++) begin
            exp_gc = (g % 9 == 8) ? 1 : 0;
            tick();
            check($sformatf("starve_host_%0d", g), int'(bus.host_grant), 1 - exp_gc);
            check($sformatf("starve_gc_%0d", g), int'(bus.gc_grant), exp_gc);
            tick();
            if (exp_gc == 1) check("gc_interrupt_bg", int'(bus.gc_interrupt), ExpInt);
            tick();
            if (exp_gc == 1) bus.request_done = 1'b1;
            else             bus.host_done    = 1'b1;
            tick();
            bus.request_done = 1'b0;
            bus.host_done    = 1'b0;
            check("starve_release", int'(bus.host_grant | bus.gc_grant), 0);
        end

        // Reset mid-grant
        bus.host_req = 1'b0;
        tick();
        check("pre_reset_gc_grant", int'(bus.gc_grant), 1);
        rst = 1'b1;
        tick();
        check("midrst_host_grant", int'(bus.host_grant), 0);
        check("midrst_gc_grant", int'(bus.gc_grant), 0);
        check("midrst_gc_start", int'(bus.gc_start), 0);
        check("midrst_state", int'(dut.state_q), int'(INIT));
        rst            = 1'b0;
        bus.ini_full   = 1'b0;
        bus.gc_request = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("init_hold_no_start", int'(bus.gc_start | bus.gc_grant), 0);
        end

        // GC preemption by host (no-op without the feature), no revocation on clean_num change
        do_reset();
        bus.ini_full  = 1'b1;
        bus.clean_num = 4'd8;
        tick();
        tick();
        tick();
        bus.gc_request = 1'b1;
        tick();
        check("pre_gc_grant", int'(bus.gc_grant), 1);
        bus.host_req  = 1'b1;
        bus.clean_num = 4'd13;
        tick();
        check("pre_gc_kept", int'(bus.gc_grant), 1);
        check("pre_interrupt", int'(bus.gc_interrupt), ExpInt);
        bus.request_done = 1'b1;
        tick();
        bus.request_done = 1'b0;
        check("pre_idle_gap", int'(bus.host_grant | bus.gc_grant), 0);
        check("pre_interrupt_drop", int'(bus.gc_interrupt), 0);
        tick();
        check("pre_host_grant", int'(bus.host_grant), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
